// File: rtl/vs_omp_scheduler.sv
// Iteration sequencer for greedy sparse recovery: orders matrix load, inner products,
// batch max search and residual update, records the chosen support and decides when to stop.
module vs_omp_scheduler #(
   parameter int unsigned COLUMNS    = 256,
   parameter int unsigned BATCH_SIZE = 64,
   parameter int unsigned MAX_ITER   = 8,
   parameter int unsigned TIMEOUT    = 4096
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        go,
   input  logic        load_matrix,
   input  logic [31:0] threshold,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  stop_reason,
   output logic [4:0]  iter_count,
   output logic        dp_start,
   output logic [1:0]  dp_command,
   input  logic        dp_done,
   output logic        mx_start,
   input  logic        mx_batch_done,
   input  logic [7:0]  mx_location,
   input  logic [31:0] mx_max_value,
   output logic        ru_start,
   input  logic        ru_done,
   output logic        support_we,
   output logic [3:0]  support_addr,
   output logic [7:0]  support_index,
   output logic [31:0] support_value
);

   localparam int unsigned BATCHES = COLUMNS / BATCH_SIZE;
   localparam int unsigned BatchW  = $clog2(BATCHES + 1);
   localparam int unsigned CntW    = $clog2(TIMEOUT + 1);

   localparam logic [1:0] CmdLoadSensingMatrix    = 2'd0;
   localparam logic [1:0] CmdComputeInnerProducts = 2'd1;

   localparam logic [1:0] ReasonSparsity  = 2'd0;
   localparam logic [1:0] ReasonThreshold = 2'd1;
   localparam logic [1:0] ReasonRepeat    = 2'd2;
   localparam logic [1:0] ReasonTimeout   = 2'd3;

   typedef enum logic [3:0] {
      StIdle, StLoadReq, StLoadWait, StIpReq, StIpWait, StMxReq, StMxWait,
      StDecide, StRecord, StRuReq, StRuWait, StFinish
   } state_e;

   state_e              state_q, state_d;
   logic [31:0]         thr_q, thr_d;
   logic [4:0]          iter_q, iter_d;
   logic [COLUMNS-1:0]  bitmap_q, bitmap_d;
   logic [1:0]          reason_q, reason_d;
   logic [BatchW-1:0]   batch_q, batch_d;
   logic [CntW-1:0]     wait_q, wait_d;
   logic                mxd_prev_q;

   logic                busy_q, done_q, error_q, dp_start_q, mx_start_q, ru_start_q, we_q;
   logic [1:0]          cmd_q, cmd_d;
   logic [3:0]          addr_q, addr_d;
   logic [7:0]          index_q, index_d;
   logic [31:0]         value_q, value_d;

   logic [31:0]         abs_val;
   logic                below;
   logic                mx_rise;
   logic                is_wait;
   logic                timed_out;

   // Most negative input has no positive twin; clamp it to the largest magnitude.
   always_comb begin
      if (!mx_max_value[31]) begin
         abs_val = mx_max_value;
      end else if (mx_max_value == 32'h8000_0000) begin
         abs_val = 32'h7FFF_FFFF;
      end else begin
         abs_val = -mx_max_value;
      end
   end

   assign below     = $signed(abs_val) < $signed(thr_q);
   assign mx_rise   = mx_batch_done & ~mxd_prev_q;
   assign is_wait   = (state_q == StLoadWait) || (state_q == StIpWait) ||
                      (state_q == StMxWait)   || (state_q == StRuWait);
   assign timed_out = is_wait && (wait_q == CntW'(TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      thr_d    = thr_q;
      iter_d   = iter_q;
      bitmap_d = bitmap_q;
      reason_d = reason_q;
      batch_d  = batch_q;

      unique case (state_q)
         StIdle: begin
            if (go) begin
               thr_d    = threshold;
               iter_d   = '0;
               bitmap_d = '0;
               reason_d = ReasonSparsity;
               state_d  = load_matrix ? StLoadReq : StIpReq;
            end
         end
         StLoadReq: state_d = StLoadWait;
         StLoadWait: begin
            if (dp_done) begin
               state_d = StIpReq;
            end else if (timed_out) begin
               state_d  = StFinish;
               reason_d = ReasonTimeout;
            end
         end
         StIpReq: state_d = StIpWait;
         StIpWait: begin
            if (dp_done) begin
               state_d = StMxReq;
               batch_d = '0;
            end else if (timed_out) begin
               state_d  = StFinish;
               reason_d = ReasonTimeout;
            end
         end
         StMxReq: state_d = StMxWait;
         StMxWait: begin
            if (mx_rise) begin
               batch_d = batch_q + 1'b1;
               state_d = (batch_d < BatchW'(BATCHES)) ? StMxReq : StDecide;
            end else if (timed_out) begin
               state_d  = StFinish;
               reason_d = ReasonTimeout;
            end
         end
         StDecide: begin
            if (below) begin
               state_d  = StFinish;
               reason_d = ReasonThreshold;
            end else if (bitmap_q[mx_location]) begin
               state_d  = StFinish;
               reason_d = ReasonRepeat;
            end else begin
               state_d = StRecord;
            end
         end
         StRecord: begin
            bitmap_d[index_q] = 1'b1;
            iter_d            = iter_q + 5'd1;
            if (iter_d == 5'(MAX_ITER)) begin
               state_d  = StFinish;
               reason_d = ReasonSparsity;
            end else begin
               state_d = StRuReq;
            end
         end
         StRuReq: state_d = StRuWait;
         StRuWait: begin
            if (ru_done) begin
               state_d = StIpReq;
            end else if (timed_out) begin
               state_d  = StFinish;
               reason_d = ReasonTimeout;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Counter restarts on every entry into a wait state, including MX_REQ -> MX_WAIT loops.
   assign wait_d = (is_wait && (state_d == state_q)) ? wait_q + 1'b1 : '0;

   // Outputs are registered from the next state so each strobe lines up with its state.
   always_comb begin
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      index_d = index_q;
      value_d = value_q;
      if (state_d == StLoadReq) begin
         cmd_d = CmdLoadSensingMatrix;
      end else if (state_d == StIpReq) begin
         cmd_d = CmdComputeInnerProducts;
      end
      if (state_d == StRecord) begin
         addr_d  = iter_q[3:0];
         index_d = mx_location;
         value_d = mx_max_value;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         thr_q      <= '0;
         iter_q     <= '0;
         bitmap_q   <= '0;
         reason_q   <= ReasonSparsity;
         batch_q    <= '0;
         wait_q     <= '0;
         mxd_prev_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         dp_start_q <= 1'b0;
         mx_start_q <= 1'b0;
         ru_start_q <= 1'b0;
         we_q       <= 1'b0;
         cmd_q      <= CmdComputeInnerProducts;
         addr_q     <= '0;
         index_q    <= '0;
         value_q    <= '0;
      end else begin
         state_q    <= state_d;
         thr_q      <= thr_d;
         iter_q     <= iter_d;
         bitmap_q   <= bitmap_d;
         reason_q   <= reason_d;
         batch_q    <= batch_d;
         wait_q     <= wait_d;
         mxd_prev_q <= mx_batch_done;
         busy_q     <= (state_d != StIdle);
         done_q     <= (state_d == StFinish);
         error_q    <= (state_d == StFinish) && (reason_d == ReasonTimeout);
         dp_start_q <= (state_d == StLoadReq) || (state_d == StIpReq);
         mx_start_q <= (state_d == StMxReq);
         ru_start_q <= (state_d == StRuReq);
         we_q       <= (state_d == StRecord);
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         index_q    <= index_d;
         value_q    <= value_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign stop_reason   = reason_q;
   assign iter_count    = iter_q;
   assign dp_start      = dp_start_q;
   assign dp_command    = cmd_q;
   assign mx_start      = mx_start_q;
   assign ru_start      = ru_start_q;
   assign support_we    = we_q;
   assign support_addr  = addr_q;
   assign support_index = index_q;
   assign support_value = value_q;

endmodule

// File: tb/tb_vs_omp_scheduler.sv
// Directed bench for vs_omp_scheduler: stub units answer after 5 cycles, tasks check each scenario.
module tb_vs_omp_scheduler;

   localparam int unsigned TIMEOUT  = 4096;
   localparam logic [1:0]  CMD_LOAD = 2'd0;
   localparam logic [1:0]  CMD_IP   = 2'd1;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        go = 1'b0;
   logic        load_matrix = 1'b0;
   logic [31:0] threshold = '0;
   logic        busy, done, error;
   logic [1:0]  stop_reason;
   logic [4:0]  iter_count;
   logic        dp_start;
   logic [1:0]  dp_command;
   logic        dp_done = 1'b0;
   logic        mx_start;
   logic        mx_batch_done = 1'b0;
   logic [7:0]  mx_location = '0;
   logic [31:0] mx_max_value = '0;
   logic        ru_start;
   logic        ru_done = 1'b0;
   logic        support_we;
   logic [3:0]  support_addr;
   logic [7:0]  support_index;
   logic [31:0] support_value;

   int vecs = 0;
   int errs = 0;

   vs_omp_scheduler #(
      .COLUMNS    (256),
      .BATCH_SIZE (64),
      .MAX_ITER   (8),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .go            (go),
      .load_matrix   (load_matrix),
      .threshold     (threshold),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .stop_reason   (stop_reason),
      .iter_count    (iter_count),
      .dp_start      (dp_start),
      .dp_command    (dp_command),
      .dp_done       (dp_done),
      .mx_start      (mx_start),
      .mx_batch_done (mx_batch_done),
      .mx_location   (mx_location),
      .mx_max_value  (mx_max_value),
      .ru_start      (ru_start),
      .ru_done       (ru_done),
      .support_we    (support_we),
      .support_addr  (support_addr),
      .support_index (support_index),
      .support_value (support_value)
   );

   always #5 clock = ~clock;

   logic [7:0]  loc_tab [8];
   logic [31:0] val_tab [8];
   bit          dp_hold = 1'b0;
   bit          mon_clr = 1'b0;
   int          dp_cnt = 0, mx_dn = 0, ru_dn = 0, ip_round = 0, cyc = 0;

   // Stub units: each answers 5 cycles after its start strobe.
   always @(posedge clock) begin
      cyc     <= cyc + 1;
      dp_done <= 1'b0;
      ru_done <= 1'b0;
      if (dp_start) dp_cnt <= 5;
      else if (dp_cnt > 0) begin
         dp_cnt <= dp_cnt - 1;
         if (dp_cnt == 1 && !dp_hold) dp_done <= 1'b1;
      end
      if (mon_clr) ip_round <= 0;
      else if (dp_start && dp_command == CMD_IP) ip_round <= ip_round + 1;
      if (mx_start) begin
         mx_batch_done <= 1'b0;
         mx_dn         <= 5;
         mx_location   <= loc_tab[(ip_round + 7) % 8];
         mx_max_value  <= val_tab[(ip_round + 7) % 8];
      end else if (mx_dn > 0) begin
         mx_dn <= mx_dn - 1;
         if (mx_dn == 1) mx_batch_done <= 1'b1;
      end
      if (ru_start) ru_dn <= 5;
      else if (ru_dn > 0) begin
         ru_dn <= ru_dn - 1;
         if (ru_dn == 1) ru_done <= 1'b1;
      end
   end

   int          done_cnt = 0, err_cnt = 0, mx_cnt = 0, load_cnt = 0, ru_cnt = 0, wr_n = 0;
   int          done_cyc = 0, dp_cyc = 0;
   logic        done_err = 1'b0;
   logic [3:0]  wr_addr [16];
   logic [7:0]  wr_idx  [16];
   logic [31:0] wr_val  [16];

   always @(negedge clock) begin
      if (mon_clr) begin
         done_cnt <= 0; err_cnt <= 0; mx_cnt <= 0; load_cnt <= 0; ru_cnt <= 0; wr_n <= 0;
      end else begin
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            done_err <= error;
         end
         if (error) err_cnt <= err_cnt + 1;
         if (mx_start) mx_cnt <= mx_cnt + 1;
         if (ru_start) ru_cnt <= ru_cnt + 1;
         if (dp_start) begin
            dp_cyc <= cyc;
            if (dp_command == CMD_LOAD) load_cnt <= load_cnt + 1;
         end
         if (support_we && wr_n < 16) begin
            wr_addr[wr_n] <= support_addr;
            wr_idx[wr_n]  <= support_index;
            wr_val[wr_n]  <= support_value;
            wr_n          <= wr_n + 1;
         end
      end
   end

   task automatic clear_mon();
      @(posedge clock); #1 mon_clr = 1'b1;
      @(posedge clock); #1 mon_clr = 1'b0;
   endtask

   task automatic start_run(input logic load, input logic [31:0] thr);
      @(negedge clock);
      go = 1'b1; load_matrix = load; threshold = thr;
      @(negedge clock);
      go = 1'b0; load_matrix = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      vecs++;
      if (!ok) begin
         errs++;
         $display("FAIL wait_done: no done within %0d cycles", budget);
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      logic [59:0] got, want;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      got  = {busy, done, error, dp_start, mx_start, ru_start, support_we, iter_count,
              stop_reason, support_addr, support_index, support_value, dp_command};
      want = {7'b0, 5'd0, 2'd0, 4'd0, 8'd0, 32'd0, CMD_IP};
      vecs++;
      if (got !== want) begin
         errs++;
         $display("FAIL reset_outputs got %h want %h", got, want);
      end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_full_run();
      bit ok;
      loc_tab = '{8'd3, 8'd17, 8'd40, 8'd55, 8'd99, 8'd128, 8'd200, 8'd255};
      val_tab = '{32'd1000, 32'hFFFF_F830, 32'd3000, 32'hFFFF_F060,
                  32'd5000, 32'd6000, 32'd7000, 32'd8000};
      clear_mon();
      start_run(1'b1, 32'd0);
      vecs++;
      if (dp_start !== 1'b1 || dp_command !== CMD_LOAD) begin
         errs++;
         $display("FAIL full_go_latency dp_start %b cmd %0d want 1 %0d", dp_start, dp_command,
                  CMD_LOAD);
      end
      repeat (30) @(negedge clock);
      go = 1'b1; load_matrix = 1'b1;
      @(negedge clock);
      go = 1'b0; load_matrix = 1'b0;
      wait_done(3000, ok);
      vecs++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errs++;
         $display("FAIL full_after_done busy %b done %b want 0 0", busy, done);
      end
      vecs++;
      if (stop_reason !== 2'd0 || iter_count !== 5'd8) begin
         errs++;
         $display("FAIL full_status reason %0d iter %0d want 0 8", stop_reason, iter_count);
      end
      vecs++;
      if (wr_n !== 8 || load_cnt !== 1 || done_cnt !== 1 || err_cnt !== 0) begin
         errs++;
         $display("FAIL full_counts writes %0d loads %0d dones %0d errs %0d want 8 1 1 0",
                  wr_n, load_cnt, done_cnt, err_cnt);
      end
      vecs++;
      if (mx_cnt !== 32 || ru_cnt !== 7) begin
         errs++;
         $display("FAIL full_mx_ru mx %0d ru %0d want 32 7", mx_cnt, ru_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         vecs++;
         if (wr_addr[i] !== 4'(i) || wr_idx[i] !== loc_tab[i] || wr_val[i] !== val_tab[i]) begin
            errs++;
            $display("FAIL full_write[%0d] got %0d/%0d/%h want %0d/%0d/%h", i, wr_addr[i],
                     wr_idx[i], wr_val[i], i, loc_tab[i], val_tab[i]);
         end
      end
   endtask

   task automatic test_repeat_atom();
      bit ok;
      loc_tab = '{8'd17, 8'd17, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
      val_tab = '{32'd900, 32'd800, 32'd700, 32'd600, 32'd500, 32'd400, 32'd300, 32'd200};
      clear_mon();
      start_run(1'b0, 32'd10);
      wait_done(2000, ok);
      vecs++;
      if (stop_reason !== 2'd2 || iter_count !== 5'd1) begin
         errs++;
         $display("FAIL repeat_status reason %0d iter %0d want 2 1", stop_reason, iter_count);
      end
      vecs++;
      if (wr_n !== 1 || wr_idx[0] !== 8'd17 || wr_addr[0] !== 4'd0 || mx_cnt !== 8) begin
         errs++;
         $display("FAIL repeat_writes n %0d idx %0d addr %0d mx %0d want 1 17 0 8", wr_n,
                  wr_idx[0], wr_addr[0], mx_cnt);
      end
   endtask

   task automatic test_threshold();
      bit ok;
      loc_tab = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      val_tab = '{32'hFFFF_FF6A, 32'd100, 32'hFFFF_FF9D, 32'd500,
                  32'd500, 32'd500, 32'd500, 32'd500};
      clear_mon();
      start_run(1'b0, 32'd100);
      wait_done(2000, ok);
      vecs++;
      if (stop_reason !== 2'd1 || iter_count !== 5'd2) begin
         errs++;
         $display("FAIL thr_status reason %0d iter %0d want 1 2", stop_reason, iter_count);
      end
      vecs++;
      if (wr_n !== 2 || wr_val[0] !== 32'hFFFF_FF6A || wr_val[1] !== 32'd100) begin
         errs++;
         $display("FAIL thr_writes n %0d v0 %h v1 %h want 2 ffffff6a 00000064", wr_n,
                  wr_val[0], wr_val[1]);
      end
      // Most negative value must saturate and so reach the full-scale threshold.
      loc_tab = '{8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
      val_tab = '{32'h8000_0000, 32'h7FFF_FFFE, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
      clear_mon();
      start_run(1'b0, 32'h7FFF_FFFF);
      wait_done(2000, ok);
      vecs++;
      if (stop_reason !== 2'd1 || iter_count !== 5'd1 || wr_n !== 1 ||
          wr_val[0] !== 32'h8000_0000) begin
         errs++;
         $display("FAIL thr_saturate reason %0d iter %0d n %0d v0 %h want 1 1 1 80000000",
                  stop_reason, iter_count, wr_n, wr_val[0]);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      dp_hold = 1'b1;
      clear_mon();
      start_run(1'b0, 32'd0);
      wait_done(TIMEOUT + 100, ok);
      vecs++;
      if (done_cyc - dp_cyc !== TIMEOUT + 1) begin
         errs++;
         $display("FAIL timeout_latency got %0d want %0d", done_cyc - dp_cyc, TIMEOUT + 1);
      end
      vecs++;
      if (done_err !== 1'b1 || err_cnt !== 1 || done_cnt !== 1) begin
         errs++;
         $display("FAIL timeout_error err_with_done %b errs %0d dones %0d want 1 1 1",
                  done_err, err_cnt, done_cnt);
      end
      vecs++;
      if (stop_reason !== 2'd3 || busy !== 1'b0 || error !== 1'b0) begin
         errs++;
         $display("FAIL timeout_status reason %0d busy %b error %b want 3 0 0", stop_reason,
                  busy, error);
      end
      dp_hold = 1'b0;
      repeat (10) @(negedge clock);
   endtask

   task automatic test_reset_mid_run();
      bit          ok;
      bit          seen;
      logic [59:0] got, want;
      loc_tab = '{8'd3, 8'd17, 8'd40, 8'd55, 8'd99, 8'd128, 8'd200, 8'd255};
      val_tab = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      clear_mon();
      start_run(1'b0, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clock);
         if (ru_start) begin
            seen = 1'b1;
            break;
         end
      end
      vecs++;
      if (!seen) begin
         errs++;
         $display("FAIL midrst_ru_start got 0 want 1");
      end
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      got  = {busy, done, error, dp_start, mx_start, ru_start, support_we, iter_count,
              stop_reason, support_addr, support_index, support_value, dp_command};
      want = {7'b0, 5'd0, 2'd0, 4'd0, 8'd0, 32'd0, CMD_IP};
      vecs++;
      if (got !== want) begin
         errs++;
         $display("FAIL midrst_outputs got %h want %h", got, want);
      end
      reset_n = 1'b1;
      repeat (10) @(negedge clock);
      vecs++;
      if (done_cnt !== 0) begin
         errs++;
         $display("FAIL midrst_no_done got %0d want 0", done_cnt);
      end
      clear_mon();
      start_run(1'b0, 32'd0);
      wait_done(3000, ok);
      vecs++;
      if (stop_reason !== 2'd0 || iter_count !== 5'd8 || wr_n !== 8 || wr_addr[0] !== 4'd0 ||
          wr_idx[0] !== 8'd3) begin
         errs++;
         $display("FAIL midrst_restart reason %0d iter %0d n %0d addr0 %0d idx0 %0d want 0 8 8 0 3",
                  stop_reason, iter_count, wr_n, wr_addr[0], wr_idx[0]);
      end
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_repeat_atom();
      test_threshold();
      test_timeout();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
